// File: rtl/layer_img_mc_if.sv
// Multi-channel image buffer with a synchronous-read CPU port, a sequencer write port,
// and a zero-fill engine. Reads use one response slot with valid/ready handshakes.
module layer_img_mc_if #(
   parameter int IMG_H  = 255,
   parameter int IMG_W  = 255,
   parameter int CH     = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 18
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_rd_req,
   output logic              cpu_rd_ready,
   input  logic [15:0]       cpu_row,
   input  logic [15:0]       cpu_col,
   input  logic [7:0]        cpu_ch,
   output logic              cpu_rvalid,
   input  logic              cpu_rready,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rerr,
   input  logic              seq_we,
   output logic              seq_ready,
   input  logic [15:0]       seq_row,
   input  logic [15:0]       seq_col,
   input  logic [7:0]        seq_ch,
   input  logic [DATA_W-1:0] seq_wdata,
   output logic              seq_err,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              clr_done
);

   localparam int PLANE  = IMG_H * IMG_W;
   localparam int DEPTH  = CH * PLANE;
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {S_IDLE, S_CLEAR} state_e;

   function automatic logic [31:0] flat_addr(input logic [15:0] row, input logic [15:0] col,
                                             input logic [7:0] ch);
      return 32'(ch) * 32'(PLANE) + 32'(row) * 32'(IMG_W) + 32'(col);
   endfunction

   function automatic logic out_of_bounds(input logic [15:0] row, input logic [15:0] col,
                                          input logic [7:0] ch);
      return (32'(row) >= 32'(IMG_H)) || (32'(col) >= 32'(IMG_W)) || (32'(ch) >= 32'(CH));
   endfunction

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic                rvalid_q, rvalid_d;
   logic                rerr_q, rerr_d;
   logic                seq_err_q, seq_err_d;
   logic                clr_done_q, clr_done_d;

   logic [31:0]         rd_addr32, wr_addr32;
   logic [ADDR_W-1:0]   rd_addr, mem_waddr;
   logic                rd_oob, wr_oob, rd_fire, wr_fire, mem_we, in_idle;
   logic [DATA_W-1:0]   mem_wdata, mem_rd_q;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic                unused_addr_bits;

   assign rd_addr32 = flat_addr(cpu_row, cpu_col, cpu_ch);
   assign wr_addr32 = flat_addr(seq_row, seq_col, seq_ch);
   assign rd_addr   = rd_addr32[ADDR_W-1:0];
   assign rd_oob    = out_of_bounds(cpu_row, cpu_col, cpu_ch);
   assign wr_oob    = out_of_bounds(seq_row, seq_col, seq_ch);

   // A clr_start seen in IDLE pre-empts both ports in the same cycle.
   assign in_idle      = (state_q == S_IDLE);
   assign seq_ready    = rst_n && in_idle && !clr_start;
   assign cpu_rd_ready = rst_n && in_idle && !clr_start && (!rvalid_q || cpu_rready);
   assign rd_fire      = cpu_rd_req && cpu_rd_ready;
   assign wr_fire      = seq_we && seq_ready;

   assign mem_we    = rst_n && ((state_q == S_CLEAR) || (wr_fire && !wr_oob));
   assign mem_waddr = (state_q == S_CLEAR) ? clr_cnt_q : wr_addr32[ADDR_W-1:0];
   assign mem_wdata = (state_q == S_CLEAR) ? '0 : seq_wdata;

   assign unused_addr_bits = ^{rd_addr32, wr_addr32, rd_addr, mem_waddr};

   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      clr_done_d = 1'b0;
      rvalid_d   = rvalid_q;
      rerr_d     = rerr_q;
      seq_err_d  = wr_fire && wr_oob;

      if (rd_fire) begin
         rvalid_d = 1'b1;
         rerr_d   = rd_oob;
      end else if (rvalid_q && cpu_rready) begin
         rvalid_d = 1'b0;
         rerr_d   = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (clr_start) begin
               state_d   = S_CLEAR;
               clr_cnt_d = '0;
            end
         end
         S_CLEAR: begin
            if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
               state_d    = S_IDLE;
               clr_cnt_d  = '0;
               clr_done_d = 1'b1;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         clr_cnt_q  <= '0;
         rvalid_q   <= 1'b0;
         rerr_q     <= 1'b0;
         seq_err_q  <= 1'b0;
         clr_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         rvalid_q   <= rvalid_d;
         rerr_q     <= rerr_d;
         seq_err_q  <= seq_err_d;
         clr_done_q <= clr_done_d;
      end
   end

   // Storage is never reset; the read register samples before the write lands (read-first).
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr[MEM_AW-1:0]] <= mem_wdata;
      if (rd_fire && !rd_oob) mem_rd_q <= mem[rd_addr[MEM_AW-1:0]];
   end

   assign cpu_rvalid = rvalid_q;
   assign cpu_rerr   = rerr_q;
   assign cpu_rdata  = (rvalid_q && !rerr_q) ? mem_rd_q : '0;
   assign seq_err    = seq_err_q;
   assign clr_busy   = (state_q == S_CLEAR);
   assign clr_done   = clr_done_q;

endmodule

// File: doc/layer_img_mc_if.md
LAYER_IMG_MC_IF -- requirements
Module: layer_img_mc_if

Interface
REQ-001 SHALL have parameter IMG_H, default 255, meaning image rows.
REQ-002 SHALL have parameter IMG_W, default 255, meaning image columns.
REQ-003 SHALL have parameter CH, default 4, meaning channel count.
REQ-004 SHALL have parameter DATA_W, default 32, meaning pixel word width.
REQ-005 SHALL have parameter ADDR_W, default 18, meaning flat address width, >= clog2(CH*IMG_H*IMG_W).
REQ-006 SHALL have one clock and a synchronous, active-low reset.
REQ-007 SHALL have ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- cpu_rd_req  in  1  read request (valid)
- cpu_rd_ready  out  1  read request accepted when high with cpu_rd_req
- cpu_row, cpu_col  in  16 each  read coordinates
- cpu_ch  in  8  read channel
- cpu_rvalid  out  1  read response valid
- cpu_rready  in  1  response consumed
- cpu_rdata  out  DATA_W  response data
- cpu_rerr  out  1  response is out-of-bounds
- seq_we  in  1  write request
- seq_ready  out  1  write accepted when high with seq_we
- seq_row, seq_col  in  16 each  write coordinates
- seq_ch  in  8  write channel
- seq_wdata  in  DATA_W  write data
- seq_err  out  1  one-cycle pulse: accepted write was out-of-bounds and dropped
- clr_start  in  1  start zero-fill of whole memory
- clr_busy  out  1  zero-fill in progress
- clr_done  out  1  one-cycle pulse after last zero-fill write

Function
REQ-008 SHALL store CH*IMG_H*IMG_W words; flat address = ch*IMG_H*IMG_W + row*IMG_W + col, computed at 32 bits then truncated to ADDR_W.
REQ-009 SHALL treat a request as out-of-bounds when row>=IMG_H or col>=IMG_W or ch>=CH.
REQ-010 SHALL use synchronous-read memory: read accepted at edge N gives cpu_rvalid=1 with data from edge N+1 on.
REQ-011 SHALL hold cpu_rvalid, cpu_rdata, cpu_rerr stable until cpu_rvalid && cpu_rready.
REQ-012 SHALL drive cpu_rd_ready = !clr_busy && (!cpu_rvalid || cpu_rready) (single response slot, back-to-back reads at full rate when cpu_rready=1).
REQ-013 SHALL return cpu_rdata=0, cpu_rerr=1 for an out-of-bounds read; in-bounds reads return cpu_rerr=0.
REQ-014 SHALL drive seq_ready = !clr_busy; accepted in-bounds write commits at that edge.
REQ-015 SHALL drop an accepted out-of-bounds write (no memory change) and pulse seq_err the next cycle.
REQ-016 SHALL accept a read and a write in the same cycle; same address: read returns old data (read-first).
REQ-017 SHALL implement FSM IDLE/CLEAR: IDLE->CLEAR on clr_start; CLEAR writes 0 to address k on cycle k, k=0..CH*IMG_H*IMG_W-1; after last write ->IDLE and clr_done=1 for one cycle.
REQ-018 SHALL assert clr_busy exactly while in CLEAR; clr_start in CLEAR is ignored.
REQ-019 SHALL, on clr_start while a read response is pending, keep that response until consumed; new reads blocked until CLEAR ends.
REQ-020 SHALL give clr_start priority over seq_we/cpu_rd_req in the same cycle (neither accepted: ready already evaluated as 1 is forbidden -> ready signals SHALL be 0 in the cycle clr_start is sampled high in IDLE).

Reset
REQ-021 SHALL on rst_n=0 at an edge set: FSM=IDLE, clear counter=0, cpu_rvalid=0, cpu_rdata=0, cpu_rerr=0, seq_err=0, clr_busy=0, clr_done=0.
REQ-022 SHALL, on reset mid-CLEAR, abort the fill without clr_done; memory contents are not altered by reset.
REQ-023 SHALL hold cpu_rd_ready=0 and seq_ready=0 while rst_n=0.

Verification (IMG_H=4, IMG_W=5, CH=2)
REQ-024 Write (r1,c2,ch1)=0xDEADBEEF, then read it -> addr 27, cpu_rvalid next cycle, cpu_rdata=0xDEADBEEF, cpu_rerr=0.
REQ-025 Read (r4,c0,ch0) and write (r0,c5,ch0) -> cpu_rdata=0, cpu_rerr=1; write dropped, seq_err pulse; memory unchanged.
REQ-026 cpu_rready=0 for 3 cycles after response -> cpu_rvalid/cpu_rdata stable, cpu_rd_ready=0; release -> next read issued same cycle.
REQ-027 Fill all 40 words nonzero, pulse clr_start -> clr_busy=1 for 40 cycles, clr_done once, all reads then return 0.
REQ-028 Simultaneous write 0x5 and read at same address holding 0x3 -> read returns 0x3, later read returns 0x5.
REQ-029 rst_n=0 at clear cycle 10 -> clr_busy=0, no clr_done, words 0..9 read 0, word 10 retains old value.
